branch_predict_unit: RTL and testbench

Parametrised branch-target unit for the CPU fetch/execute path. It computes the resolved branch target as `pc_plus_4 + (offset << 2)`. It also holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so fetch can predict taken branches one lookup ahead. Statistics counters record resolved branches and mispredictions for debug readout.

---
 rtl/branch_predict_unit.sv | 106 ++++++++++
 tb/tb_branch_predict_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - branch target adder, direct-mapped BTB with 2-bit counters, resolve stats
module branch_predict_unit #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = ADDR_W - IDX_W - 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic              predict_taken,
    output logic [ADDR_W-1:0] predict_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_pc_plus_4,
    input  logic [ADDR_W-1:0] upd_offset,
    input  logic              upd_taken,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic [ADDR_W-1:0] branch_addr,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       branch_cnt,
    output logic [31:0]       mispredict_cnt
);

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];
    logic [31:0]        r_branch_cnt;
    logic [31:0]        r_mispredict_cnt;

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic [IDX_W-1:0]   w_upd_idx;
    logic [TAG_W-1:0]   w_upd_tag;
    logic               w_upd_hit;
    logic               w_target_wrong;

    // Byte-offset bits of the PCs and the top two offset bits (shifted out) never matter.
    logic               w_unused_bits;
    assign w_unused_bits = &{1'b0, pc[1:0], upd_pc[1:0], upd_offset[ADDR_W-1:ADDR_W-2]};

    assign w_idx     = pc[IDX_W+1:2];
    assign w_tag     = pc[ADDR_W-1:IDX_W+2];
    assign w_upd_idx = upd_pc[IDX_W+1:2];
    assign w_upd_tag = upd_pc[ADDR_W-1:IDX_W+2];

    // Lookup reads the array as it stood before this edge: no write-through bypass.
    always_comb begin
        w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
        predict_taken  = w_hit && r_ctr[w_idx][1];
        predict_target = predict_taken ? r_target[w_idx] : pc + ADDR_W'(4);
    end

    // Resolve path: target arithmetic is free-running, redirect only when the branch is live.
    always_comb begin
        branch_addr    = upd_pc_plus_4 + {upd_offset[ADDR_W-3:0], 2'b00};
        w_target_wrong = upd_pred_target != branch_addr;
        mispredict     = upd_valid && ((upd_taken != upd_pred_taken) ||
                                       (upd_taken && upd_pred_taken && w_target_wrong));
        redirect_pc    = upd_taken ? branch_addr : upd_pc_plus_4;
        w_upd_hit      = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    end

    // BTB training and stats; reset wipes everything and swallows a concurrent update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid          <= '0;
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b00;
            end
        end else if (upd_valid) begin
            r_branch_cnt <= r_branch_cnt + 32'd1;
            if (mispredict) begin
                r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
            end
            if (w_upd_hit) begin
                if (upd_taken) begin
                    r_target[w_upd_idx] <= branch_addr;
                    if (r_ctr[w_upd_idx] != 2'b11) begin
                        r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'd1;
                    end
                end else if (r_ctr[w_upd_idx] != 2'b00) begin
                    r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Taken miss claims the slot outright, evicting any alias.
                r_valid[w_upd_idx]  <= 1'b1;
                r_tag[w_upd_idx]    <= w_upd_tag;
                r_target[w_upd_idx] <= branch_addr;
                r_ctr[w_upd_idx]    <= 2'b10;
            end
        end
    end

    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - scoreboard bench for branch_predict_unit
module tb_branch_predict_unit;

    localparam int SIG_PT   = 0;
    localparam int SIG_PTG  = 1;
    localparam int SIG_BA   = 2;
    localparam int SIG_MIS  = 3;
    localparam int SIG_RED  = 4;
    localparam int SIG_BCNT = 5;
    localparam int SIG_MCNT = 6;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_pc_plus_4;
    logic [31:0] upd_offset;
    logic        upd_taken;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic [31:0] branch_addr;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    branch_predict_unit #(.ADDR_W(32), .ENTRIES(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .predict_taken   (predict_taken),
        .predict_target  (predict_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_pc_plus_4   (upd_pc_plus_4),
        .upd_offset      (upd_offset),
        .upd_taken       (upd_taken),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .branch_addr     (branch_addr),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .branch_cnt      (branch_cnt),
        .mispredict_cnt  (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    // Reference BTB: 16 entries, index pc[5:2], tag pc[31:6].
    logic        m_init = 1'b0;
    logic        m_valid  [16];
    logic [25:0] m_tag    [16];
    logic [31:0] m_target [16];
    logic [1:0]  m_ctr    [16];
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            SIG_PT:   return {31'd0, predict_taken};
            SIG_PTG:  return predict_target;
            SIG_BA:   return branch_addr;
            SIG_MIS:  return {31'd0, mispredict};
            SIG_RED:  return redirect_pc;
            SIG_BCNT: return branch_cnt;
            default:  return mispredict_cnt;
        endcase
    endfunction

    function automatic logic m_hit(input logic [31:0] a);
        return m_valid[a[5:2]] && (m_tag[a[5:2]] == a[31:6]);
    endfunction

    function automatic logic m_pt(input logic [31:0] a);
        return m_hit(a) && m_ctr[a[5:2]][1];
    endfunction

    function automatic logic [31:0] m_ptg(input logic [31:0] a);
        return m_pt(a) ? m_target[a[5:2]] : a + 32'd4;
    endfunction

    function automatic logic [31:0] m_ba();
        return upd_pc_plus_4 + (upd_offset << 2);
    endfunction

    function automatic logic m_mis();
        return upd_valid && ((upd_taken != upd_pred_taken) ||
               (upd_taken && upd_pred_taken && (upd_pred_target != m_ba())));
    endfunction

    task automatic push(input string tag, input int sig, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of stimulus and push the model's expectations for it.
    task automatic drive(input logic r, input logic [31:0] p, input logic v,
                         input logic [31:0] upc, input logic [31:0] upp4,
                         input logic [31:0] off, input logic t,
                         input logic upt, input logic [31:0] uptg);
        rst             = r;
        pc              = p;
        upd_valid       = v;
        upd_pc          = upc;
        upd_pc_plus_4   = upp4;
        upd_offset      = off;
        upd_taken       = t;
        upd_pred_taken  = upt;
        upd_pred_target = uptg;
        push("branch_addr", SIG_BA, m_ba());
        push("mispredict", SIG_MIS, {31'd0, m_mis()});
        push("redirect_pc", SIG_RED, t ? m_ba() : upp4);
        if (m_init) begin
            push("predict_taken", SIG_PT, {31'd0, m_pt(p)});
            push("predict_target", SIG_PTG, m_ptg(p));
            push("branch_cnt", SIG_BCNT, m_bcnt);
            push("mispredict_cnt", SIG_MCNT, m_mcnt);
        end
    endtask

    // Compare all queued expectations mid-cycle, then clock the model along with the DUT.
    task automatic settle();
        logic [3:0] ui;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check(e.tag, observe(e.sig), e.exp);
        end
        @(posedge clk);
        ui = upd_pc[5:2];
        if (rst) begin
            m_init = 1'b1;
            m_bcnt = '0;
            m_mcnt = '0;
            for (int i = 0; i < 16; i++) begin
                m_valid[i]  = 1'b0;
                m_tag[i]    = '0;
                m_target[i] = '0;
                m_ctr[i]    = 2'b00;
            end
        end else if (upd_valid) begin
            m_bcnt = m_bcnt + 1;
            if (m_mis()) m_mcnt = m_mcnt + 1;
            if (m_hit(upd_pc)) begin
                if (upd_taken) begin
                    m_target[ui] = m_ba();
                    if (m_ctr[ui] < 2'b11) m_ctr[ui] = m_ctr[ui] + 1;
                end else if (m_ctr[ui] > 2'b00) begin
                    m_ctr[ui] = m_ctr[ui] - 1;
                end
            end else if (upd_taken) begin
                m_valid[ui]  = 1'b1;
                m_tag[ui]    = upd_pc[31:6];
                m_target[ui] = m_ba();
                m_ctr[ui]    = 2'b10;
            end
        end
        #1;
    endtask

    task automatic idle(input logic [31:0] p);
        drive(1'b0, p, 1'b0, 32'h0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Branch at a, resolving with the outcome t, carrying the model's own fetch prediction.
    task automatic resolve(input logic [31:0] p, input logic [31:0] a, input logic [31:0] off, input logic t);
        logic        pt;
        logic [31:0] ptg;
        pt  = m_init ? m_pt(a) : 1'b0;
        ptg = m_init ? m_ptg(a) : a + 32'd4;
        drive(1'b0, p, 1'b1, a, a + 32'd4, off, t, pt, ptg);
    endtask

    initial begin
        rst = 1'b0; pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_pc_plus_4 = '0;
        upd_offset = '0; upd_taken = 1'b0; upd_pred_taken = 1'b0; upd_pred_target = '0;
        @(posedge clk); #1;

        // Reset with a colliding taken update: update must be discarded.
        drive(1'b1, 32'h40, 1'b1, 32'h40, 32'h44, 32'h3, 1'b1, 1'b0, 32'h0);
        push("rst_ba_live", SIG_BA, 32'h50);
        push("rst_mis_live", SIG_MIS, 32'h1);
        settle();

        idle(32'h40);
        push("empty_pt", SIG_PT, 32'h0);
        push("empty_ptg", SIG_PTG, 32'h44);
        push("empty_bcnt", SIG_BCNT, 32'h0);
        push("empty_mcnt", SIG_MCNT, 32'h0);
        settle();

        // Allocate at 0x40 with a concurrent lookup of the same PC.
        drive(1'b0, 32'h40, 1'b1, 32'h40, 32'h44, 32'h3, 1'b1, 1'b0, 32'h44);
        push("alloc_ba", SIG_BA, 32'h50);
        push("alloc_mis", SIG_MIS, 32'h1);
        push("alloc_red", SIG_RED, 32'h50);
        push("bypass_pt", SIG_PT, 32'h0);
        settle();

        idle(32'h40);
        push("alloc_pt", SIG_PT, 32'h1);
        push("alloc_ptg", SIG_PTG, 32'h50);
        push("alloc_mcnt", SIG_MCNT, 32'h1);
        settle();

        // Negative offset and wraparound, with no live branch.
        drive(1'b0, 32'h40, 1'b0, 32'h40, 32'h44, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0);
        push("neg_ba", SIG_BA, 32'h3C);
        push("novalid_mis", SIG_MIS, 32'h0);
        settle();
        drive(1'b0, 32'h40, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
        push("wrap_ba", SIG_BA, 32'hFFFF_FFFC);
        settle();

        // Hysteresis: two not-taken, then four taken, then one not-taken (saturated at 11).
        resolve(32'h40, 32'h40, 32'h3, 1'b0); settle();
        idle(32'h40);
        push("hyst_weak_nt_pt", SIG_PT, 32'h0);
        settle();
        resolve(32'h40, 32'h40, 32'h3, 1'b0); settle();
        for (int i = 0; i < 4; i++) begin
            resolve(32'h40, 32'h40, 32'h3, 1'b1); settle();
        end
        resolve(32'h40, 32'h40, 32'h3, 1'b0); settle();
        idle(32'h40);
        push("sat_pt", SIG_PT, 32'h1);
        settle();

        // Taken with the right direction but a stale predicted target.
        drive(1'b0, 32'h40, 1'b1, 32'h40, 32'h44, 32'h8, 1'b1, 1'b1, 32'h50);
        push("tgt_mis", SIG_MIS, 32'h1);
        settle();

        // Aliasing on index 0: 0x80 evicts 0x40, not-taken 0xC0 leaves it alone.
        resolve(32'h40, 32'h80, 32'h10, 1'b1); settle();
        idle(32'h40);
        push("evict_pt", SIG_PT, 32'h0);
        settle();
        resolve(32'h80, 32'hC0, 32'h10, 1'b0); settle();
        idle(32'h80);
        push("alias_keep_pt", SIG_PT, 32'h1);
        push("alias_keep_ptg", SIG_PTG, 32'hC4);
        settle();

        // Constrained random traffic over a handful of aliasing PCs.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [31:0] p;
            logic [31:0] off;
            logic        upt;
            logic [31:0] uptg;
            a    = 32'h40 * $urandom_range(0, 5);
            p    = 32'h40 * $urandom_range(0, 5);
            off  = $urandom_range(0, 1) ? 32'(($urandom_range(0, 63))) : 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
            upt  = $urandom_range(0, 3) != 0 ? m_pt(a) : 1'($urandom_range(0, 1));
            uptg = $urandom_range(0, 3) != 0 ? m_ptg(a) : $urandom;
            drive(1'($urandom_range(0, 19) == 0), p, 1'($urandom_range(0, 3) != 0), a, a + 32'd4,
                  off, 1'($urandom_range(0, 1)), upt, uptg);
            settle();
        end

        // Mid-operation reset drops everything learned.
        resolve(32'h80, 32'h80, 32'h4, 1'b1); settle();
        drive(1'b1, 32'h80, 1'b0, 32'h0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0); settle();
        idle(32'h80);
        push("post_rst_pt", SIG_PT, 32'h0);
        push("post_rst_ptg", SIG_PTG, 32'h84);
        push("post_rst_bcnt", SIG_BCNT, 32'h0);
        push("post_rst_mcnt", SIG_MCNT, 32'h0);
        settle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
